// File: rtl/serial_word_tx_if.sv
// serial_word_tx_if: word request and serial line bundle for serial_word_tx
interface serial_word_tx_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] data_in;
  logic x_out;
  logic valid_out;
  logic busy;
  logic done;
  logic [1:0] state;
  modport master(output start, data_in, input x_out, valid_out, busy, done, state);
  modport slave(input start, data_in, output x_out, valid_out, busy, done, state);
endinterface

// File: rtl/serial_word_tx.sv
// serial_word_tx: bit-serial word transmitter, even parity bit when SERIAL_TX_PARITY_EN is defined
module serial_word_tx #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic clk,
  input logic rst,
  serial_word_tx_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'b00, SHIFT = 2'b01, PARITY = 2'b10, DONE = 2'b11;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [1:0] AFTER_SHIFT = PARITY, AFTER_PARITY = DONE;
`else
  localparam logic [1:0] AFTER_SHIFT = DONE, AFTER_PARITY = IDLE;
`endif
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0] cnt_q, idx;
  logic accept, last, in_par, par_bit;
  assign accept = (state_q == IDLE || state_q == DONE) && bus.start;
  assign last = cnt_q == CW'(WIDTH - 1);
  assign idx = MSB_FIRST ? CW'(WIDTH - 1) - cnt_q : cnt_q;
`ifdef SERIAL_TX_PARITY_EN
  assign in_par = state_q == PARITY;
  assign par_bit = ^data_q;
`else
  assign in_par = 1'b0;
  assign par_bit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= bus.data_in;
        cnt_q <= '0;
      end else if (state_q == SHIFT && !last) cnt_q <= cnt_q + 1'b1;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE)  ? (bus.start ? SHIFT : IDLE) :
              (state_q == SHIFT) ? (last ? AFTER_SHIFT : SHIFT) :
              (state_q == DONE)  ? (bus.start ? SHIFT : IDLE) : AFTER_PARITY;
  end
  always_comb begin
    bus.state = state_q;
    bus.busy = state_q == SHIFT || in_par;
    bus.valid_out = state_q == SHIFT || in_par;
    bus.done = state_q == DONE;
    bus.x_out = (state_q == SHIFT) ? data_q[idx] : (in_par & par_bit);
  end
endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: scoreboard bench for MSB-first and LSB-first serial_word_tx instances
module tb_serial_word_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = 9;
  localparam bit PAR = 1'b1;
`else
  localparam int NB = 8;
  localparam bit PAR = 1'b0;
`endif
  serial_word_tx_if #(.WIDTH(8)) ifa();
  serial_word_tx_if #(.WIDTH(8)) ifb();
  serial_word_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a(.clk(clk), .rst(rst), .bus(ifa.slave));
  serial_word_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b(.clk(clk), .rst(rst), .bus(ifb.slave));
  bit qa[$];
  bit qb[$];
  int tests = 0;
  int fails = 0;
  int da_cnt = 0;
  int db_cnt = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push_a(input logic [7:0] seq, input bit par);
    for (int i = 7; i >= 0; i--) qa.push_back(seq[i]);
    if (PAR) qa.push_back(par);
  endtask
  task automatic push_b(input logic [7:0] seq, input bit par);
    for (int i = 7; i >= 0; i--) qb.push_back(seq[i]);
    if (PAR) qb.push_back(par);
  endtask
  task automatic wait_done(input bit sel, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? ifb.done : ifa.done) && n < 30);
  endtask
  always @(negedge clk) begin
    if (ifa.valid_out) begin
      if (qa.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_extra_bit: got %0b expected no valid bit", ifa.x_out);
      end else check("a_bit", ifa.x_out, qa.pop_front());
    end
    if (ifb.valid_out) begin
      if (qb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_extra_bit: got %0b expected no valid bit", ifb.x_out);
      end else check("b_bit", ifb.x_out, qb.pop_front());
    end
    if (ifa.done) da_cnt++;
    if (ifb.done) db_cnt++;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    int d0;
    ifa.start = 1'b1;
    ifa.data_in = 8'hA5;
    ifb.start = 1'b1;
    ifb.data_in = 8'h01;
    repeat (2) @(negedge clk);
    check("rst_a", {ifa.state, ifa.x_out, ifa.valid_out, ifa.busy, ifa.done}, 0);
    check("rst_b", {ifb.state, ifb.x_out, ifb.valid_out, ifb.busy, ifb.done}, 0);
    rst = 1'b0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    @(negedge clk);
    check("idle_after_rst", {ifa.state, ifb.state}, 0);
    push_a(8'b10100101, 1'b0);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    ifa.data_in = 8'h00;
    check("a5_shift", {ifa.state, ifa.busy, ifa.valid_out}, 5'b01_1_1);
    wait_done(1'b0, n);
    check("a5_latency", n, NB);
    check("a5_done", {ifa.state, ifa.valid_out, ifa.busy, ifa.x_out}, 5'b11_000);
    @(negedge clk);
    check("a5_idle", {ifa.state, ifa.done}, 0);
    push_b(8'b10000000, 1'b1);
    ifb.data_in = 8'h01;
    ifb.start = 1'b1;
    @(negedge clk);
    ifb.start = 1'b0;
    ifb.data_in = 8'hFF;
    wait_done(1'b1, n);
    check("lsb_latency", n, NB);
    push_a(8'b11110000, 1'b0);
    push_a(8'b00001111, 1'b0);
    ifa.data_in = 8'hF0;
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.data_in = 8'h0F;
    wait_done(1'b0, n);
    check("b2b_first", n, NB);
    @(negedge clk);
    ifa.start = 1'b0;
    check("b2b_no_idle", ifa.state, 2'b01);
    wait_done(1'b0, n);
    check("b2b_second", n, NB);
    @(negedge clk);
    push_a(8'b00000111, 1'b1);
    ifa.data_in = 8'h07;
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    repeat (7) @(negedge clk);
    @(negedge clk);
`ifdef SERIAL_TX_PARITY_EN
    check("p07_parity", {ifa.state, ifa.x_out, ifa.valid_out}, 4'b10_1_1);
    @(negedge clk);
`endif
    check("p07_done", {ifa.state, ifa.done}, 3'b11_1);
    @(negedge clk);
    push_a(8'b00000011, 1'b0);
    ifa.data_in = 8'h03;
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    repeat (7) @(negedge clk);
    @(negedge clk);
`ifdef SERIAL_TX_PARITY_EN
    check("p03_parity", {ifa.state, ifa.x_out, ifa.valid_out}, 4'b10_0_1);
    @(negedge clk);
`endif
    check("p03_done", {ifa.state, ifa.done}, 3'b11_1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) qb.push_back(1'b1);
    ifb.data_in = 8'hFF;
    ifb.start = 1'b1;
    @(negedge clk);
    ifb.start = 1'b0;
    repeat (3) @(negedge clk);
    d0 = db_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs", {ifb.state, ifb.x_out, ifb.valid_out, ifb.busy}, 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_done", db_cnt, d0);
    check("abort_idle", ifb.state, 2'b00);
    check("qa_empty", qa.size(), 0);
    check("qb_empty", qb.size(), 0);
    check("done_count_a", da_cnt, 5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
